nodf_handshake_tracker: RTL and testbench

//  Cycle-accurate status/performance tracker for one non-dataflow HLS block (ap_ctrl_hs handshake).

---
 rtl/nodf_trk_pkg.sv | 23 ++
 rtl/nodf_handshake_tracker_if.sv | 14 +
 rtl/nodf_ts_fifo.sv | 56 +++++
 rtl/nodf_handshake_tracker.sv | 131 +++++++++++++
 tb/tb_nodf_handshake_tracker.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nodf_trk_pkg.sv
// Shared types and helpers for the ap_ctrl_hs handshake tracker.
// Holds the status encoding, default sizes and a saturating increment.
package nodf_trk_pkg;

    localparam int DEF_CNT_W    = 32;
    localparam int DEF_MAX_INFL = 4;
    localparam int SAT_W        = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_BUSY       = 3'd2,
        ST_DONE_STALL = 3'd3,
        ST_FINISHED   = 3'd4
    } status_e;

    // Operates on a SAT_W-bit container so any counter up to SAT_W bits can share it.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? max_value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/nodf_handshake_tracker_if.sv
// ap_ctrl_hs handshake bundle observed by the tracker, plus the end-of-run finish strobe.
// Input side accepts on ap_start & ap_ready; result side completes on ap_done & ap_continue.
interface nodf_handshake_tracker_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;
    logic finish;

    modport master (output ap_start, ap_ready, ap_done, ap_continue, finish);
    modport slave  (input  ap_start, ap_ready, ap_done, ap_continue, finish);

endinterface

// File: rtl/nodf_ts_fifo.sv
// Circular FIFO of start timestamps for in-flight transactions.
// Push and pop may happen in the same cycle, including while full.
module nodf_ts_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nodf_handshake_tracker.sv
// Status and performance tracker for one ap_ctrl_hs HLS block: classifies each cycle,
// counts transactions, busy and stall cycles, and measures per-transaction latency.
module nodf_handshake_tracker
    import nodf_trk_pkg::*;
#(
    parameter  int CNT_W    = DEF_CNT_W,
    parameter  int MAX_INFL = DEF_MAX_INFL,
    localparam int INF_W    = $clog2(MAX_INFL + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    nodf_handshake_tracker_if.slave  hs,
    output logic [2:0]               status,
    output logic [INF_W-1:0]         inflight,
    output logic [CNT_W-1:0]         start_cnt,
    output logic [CNT_W-1:0]         done_cnt,
    output logic [CNT_W-1:0]         busy_cycles,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         last_lat,
    output logic [CNT_W-1:0]         min_lat,
    output logic [CNT_W-1:0]         max_lat,
    output logic                     lat_valid,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic                     finished
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] now_q, ts_start_q, push_ts, head_ts, cmp_ts, lat;
    logic             pending_q, finished_q, active;
    logic             start_edge, accept, complete, stall;
    logic             bypass, ovf, unf, do_push, do_pop, lat_upd, busy_now;
    logic             fifo_full, fifo_empty;
    status_e          status_q, status_d;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_W'(v), SAT_W'(CNT_MAX)));
    endfunction

    assign active     = ~finished_q;
    assign start_edge = hs.ap_start & ~pending_q;
    assign accept     = hs.ap_start & hs.ap_ready;
    assign complete   = hs.ap_done & hs.ap_continue;
    assign stall      = hs.ap_done & ~hs.ap_continue;
    assign push_ts    = pending_q ? ts_start_q : now_q;

    // Empty-FIFO accept+complete bypasses the FIFO; a full FIFO with a completion pops then pushes.
    assign bypass   = accept & complete & fifo_empty;
    assign ovf      = accept & fifo_full & ~complete;
    assign unf      = complete & fifo_empty & ~accept;
    assign do_push  = active & accept & ~bypass & ~ovf;
    assign do_pop   = active & complete & ~fifo_empty;
    assign cmp_ts   = fifo_empty ? push_ts : head_ts;
    assign lat      = now_q - cmp_ts + CNT_W'(1);
    assign lat_upd  = complete & ~unf;
    // A raised ap_start counts as busy even on the cycle it is first seen.
    assign busy_now = hs.ap_start | pending_q | (inflight != '0);

    nodf_ts_fifo #(.DEPTH(MAX_INFL), .W(CNT_W)) u_ts_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (do_push),
        .push_data (push_ts),
        .pop       (do_pop),
        .head      (head_ts),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

    always_comb begin
        status_d = ST_IDLE;
        if (hs.finish | finished_q)                    status_d = ST_FINISHED;
        else if (stall)                                status_d = ST_DONE_STALL;
        else if (pending_q | (hs.ap_start & ~hs.ap_ready)) status_d = ST_WAIT_READY;
        else if (inflight != '0)                       status_d = ST_BUSY;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) status_q <= ST_IDLE;
        else        status_q <= status_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            now_q         <= '0;
            ts_start_q    <= '0;
            pending_q     <= 1'b0;
            finished_q    <= 1'b0;
            start_cnt     <= '0;
            done_cnt      <= '0;
            busy_cycles   <= '0;
            stall_cycles  <= '0;
            last_lat      <= '0;
            min_lat       <= '1;
            max_lat       <= '0;
            lat_valid     <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            now_q     <= now_q + CNT_W'(1);
            lat_valid <= 1'b0;
            if (hs.finish) finished_q <= 1'b1;
            if (active) begin
                if (accept) begin
                    pending_q <= 1'b0;
                end else if (start_edge) begin
                    pending_q  <= 1'b1;
                    ts_start_q <= now_q;
                end
                if (accept)   start_cnt    <= bump(start_cnt);
                if (complete) done_cnt     <= bump(done_cnt);
                if (busy_now) busy_cycles  <= bump(busy_cycles);
                if (stall)    stall_cycles <= bump(stall_cycles);
                if (lat_upd) begin
                    last_lat  <= lat;
                    lat_valid <= 1'b1;
                    if (lat < min_lat) min_lat <= lat;
                    if (lat > max_lat) max_lat <= lat;
                end
                if (ovf) err_overflow  <= 1'b1;
                if (unf) err_underflow <= 1'b1;
            end
        end
    end

    assign status   = status_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_nodf_handshake_tracker.sv
// Bench for nodf_handshake_tracker: directed handshake sequences, latency scoreboard
// keyed on lat_valid, and direct counter/flag checks.
module tb_nodf_handshake_tracker;

    localparam int W        = 32;
    localparam int MAX_INFL = 4;
    localparam int INF_W    = 3;
    localparam logic [W-1:0] ALL_ONES = '1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    nodf_handshake_tracker_if hs_if ();

    logic [2:0]       status;
    logic [INF_W-1:0] inflight;
    logic [W-1:0]     start_cnt, done_cnt, busy_cycles, stall_cycles;
    logic [W-1:0]     last_lat, min_lat, max_lat;
    logic             lat_valid, err_overflow, err_underflow, finished;

    nodf_handshake_tracker #(.CNT_W(W), .MAX_INFL(MAX_INFL)) dut (
        .clock         (clock),
        .reset         (reset),
        .hs            (hs_if),
        .status        (status),
        .inflight      (inflight),
        .start_cnt     (start_cnt),
        .done_cnt      (done_cnt),
        .busy_cycles   (busy_cycles),
        .stall_cycles  (stall_cycles),
        .last_lat      (last_lat),
        .min_lat       (min_lat),
        .max_lat       (max_lat),
        .lat_valid     (lat_valid),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .finished      (finished)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic d, input logic c, input logic f);
        hs_if.ap_start    = s;
        hs_if.ap_ready    = r;
        hs_if.ap_done     = d;
        hs_if.ap_continue = c;
        hs_if.finish      = f;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Every lat_valid pulse must match the oldest expected latency.
    always @(negedge clock) begin
        if (lat_valid) begin
            if (exp_q.size() == 0) check("lat_valid_unexpected", W'(lat_valid), 0);
            else                   check("last_lat", last_lat, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_status", W'(status), 0);
        check("rst_inflight", W'(inflight), 0);
        check("rst_start_cnt", start_cnt, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_busy", busy_cycles, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_last_lat", last_lat, 0);
        check("rst_min_lat", min_lat, ALL_ONES);
        check("rst_max_lat", max_lat, 0);
        check("rst_lat_valid", W'(lat_valid), 0);
        check("rst_err_ovf", W'(err_overflow), 0);
        check("rst_err_unf", W'(err_underflow), 0);
        check("rst_finished", W'(finished), 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Single transaction: start held 4 cycles, ready+done on the 5th -> latency 5
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, c == 4, c == 4, 1'b1, 1'b0);
            if (c == 4) exp_q.push_back(5);
            @(negedge clock);
            if (c == 2) check("t1_status_wait", W'(status), 1);
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t1_lat_valid_hi", W'(lat_valid), 1);
        check("t1_start_cnt", start_cnt, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_min_lat", min_lat, 5);
        check("t1_max_lat", max_lat, 5);
        check("t1_busy", busy_cycles, 5);
        check("t1_inflight", W'(inflight), 0);
        next_cycle();
        @(negedge clock);
        check("t1_lat_valid_pulse", W'(lat_valid), 0);
        next_cycle();

        // Combinational block: start/ready/done together -> latency 1, bypass
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(1);
        next_cycle();
        idle();
        @(negedge clock);
        check("t2_inflight", W'(inflight), 0);
        check("t2_status", W'(status), 0);
        check("t2_err_ovf", W'(err_overflow), 0);
        check("t2_err_unf", W'(err_underflow), 0);
        check("t2_start_cnt", start_cnt, 2);
        check("t2_done_cnt", done_cnt, 2);
        check("t2_min_lat", min_lat, 1);
        check("t2_max_lat", max_lat, 5);
        next_cycle();

        // Pipelined: accepts on cycles 0..2, dones on 6..8 -> latency 7 each
        for (int c = 0; c < 9; c++) begin
            drive(c < 3, c < 3, c >= 6, 1'b1, 1'b0);
            if (c >= 6) exp_q.push_back(7);
            @(negedge clock);
            if (c == 3) check("t3_inflight_peak", W'(inflight), 3);
            if (c == 4) check("t3_status_busy", W'(status), 2);
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t3_inflight", W'(inflight), 0);
        check("t3_start_cnt", start_cnt, 5);
        check("t3_done_cnt", done_cnt, 5);
        check("t3_max_lat", max_lat, 7);
        next_cycle();

        // Stall: done held 4 cycles without continue, released on the 5th
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, c == 0, c >= 1, c == 5, 1'b0);
            if (c == 5) exp_q.push_back(6);
            @(negedge clock);
            if (c == 2) check("t4_status_stall", W'(status), 3);
            if (c == 5) check("t4_done_held", done_cnt, 5);
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t4_stall_cycles", stall_cycles, 4);
        check("t4_done_cnt", done_cnt, 6);
        next_cycle();

        // Underflow: completion with nothing outstanding
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        idle();
        @(negedge clock);
        check("t5_err_unf", W'(err_underflow), 1);
        check("t5_err_ovf_clear", W'(err_overflow), 0);
        check("t5_done_cnt", done_cnt, 7);
        check("t5_inflight", W'(inflight), 0);
        next_cycle();

        // Overflow: MAX_INFL+1 accepts, then drain the four stored ones
        for (int c = 0; c < 9; c++) begin
            drive(c < 5, c < 5, c >= 5, 1'b1, 1'b0);
            if (c >= 5) exp_q.push_back(6);
            @(negedge clock);
            if (c == 5) begin
                check("t5_inflight_full", W'(inflight), 4);
                check("t5_err_ovf", W'(err_overflow), 1);
                check("t5_start_cnt", start_cnt, 11);
            end
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t5_drained", W'(inflight), 0);
        check("t5_done_after_drain", done_cnt, 11);
        next_cycle();

        // Finish freezes everything
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        idle();
        @(negedge clock);
        check("t6_finished", W'(finished), 1);
        check("t6_status_fin", W'(status), 4);
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0:       drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
                1:       drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                2:       drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
                5:       drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                default: drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t6_start_frozen", start_cnt, 11);
        check("t6_done_frozen", done_cnt, 11);
        check("t6_stall_frozen", stall_cycles, 4);
        check("t6_min_frozen", min_lat, 1);
        check("t6_max_frozen", max_lat, 7);
        check("t6_last_frozen", last_lat, 6);
        check("t6_inflight_frozen", W'(inflight), 0);
        check("t6_ovf_sticky", W'(err_overflow), 1);
        check("t6_unf_sticky", W'(err_underflow), 1);
        check("t6_status_still", W'(status), 4);
        next_cycle();

        // Async reset mid-transaction discards all state
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("t7_inflight_pre", W'(inflight), 1);
        check("t7_start_pre", start_cnt, 1);
        next_cycle();
        #2 reset = 1'b0;
        #1;
        check("t7_rst_inflight", W'(inflight), 0);
        check("t7_rst_start", start_cnt, 0);
        check("t7_rst_busy", busy_cycles, 0);
        check("t7_rst_finished", W'(finished), 0);
        check("t7_rst_status", W'(status), 0);
        check("t7_rst_min", min_lat, ALL_ONES);
        check("t7_rst_ovf", W'(err_overflow), 0);
        idle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, c == 2, c == 2, 1'b1, 1'b0);
            if (c == 2) exp_q.push_back(3);
            @(negedge clock);
            next_cycle();
        end
        idle();
        @(negedge clock);
        check("t7_start_cnt", start_cnt, 1);
        check("t7_done_cnt", done_cnt, 1);
        check("t7_min_lat", min_lat, 3);
        check("t7_max_lat", max_lat, 3);
        next_cycle();
        repeat (2) next_cycle();

        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
